boreal_adc_frame_sched: RTL and testbench

- Sequences full ADS1299 RDATAC frames: 27 bytes, i.e. 3 status bytes plus 8 channels × 3 bytes.
- Drives a byte-level SPI engine and commits the captured frame to a stable 192-bit raw8 bus.
- Then dispatches channels 0..7 to the adaptive core using a valid/ready handshake.
- Replaces the DRDY-as-valid shortcut and the free-running round-robin tick between the ADC and the core.

---
 rtl/boreal_v3_pkg.sv | 33 +++
 rtl/boreal_drdy_sync.sv | 35 +++
 rtl/boreal_adc_frame_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_boreal_adc_frame_sched.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_v3_pkg.sv
// Shared frame geometry, state encoding and channel-ordering helper for the
// Boreal v3 ADS1299 front end.
package boreal_v3_pkg;

    localparam int N_CH         = 8;
    localparam int BYTES_PER_CH = 3;
    localparam int STATUS_BYTES = 3;
    localparam int FRAME_BYTES  = STATUS_BYTES + N_CH * BYTES_PER_CH;
    localparam int RAW_W        = N_CH * BYTES_PER_CH * 8;
    localparam int SHADOW_W     = FRAME_BYTES * 8;

    localparam logic [3:0] ADS_STATUS_HDR = 4'hC;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        XFER,
        CS_HOLD,
        DISPATCH
    } sched_state_e;

    // Bytes shift in at the bottom, so channel 0 ends up highest in the
    // shadow; flip the 24-bit words so channel k sits at [24k+23:24k].
    function automatic logic [RAW_W-1:0] reorder_channels(input logic [SHADOW_W-1:0] shadow);
        logic [RAW_W-1:0] raw;
        raw = '0;
        for (int k = 0; k < N_CH; k++) begin
            raw[24*k +: 24] = shadow[24*(N_CH-1-k) +: 24];
        end
        return raw;
    endfunction

endpackage

// File: rtl/boreal_drdy_sync.sv
// Two-flop synchroniser for an active-low asynchronous ready line, plus a
// one-cycle pulse on the falling edge of the synchronised level.
module boreal_drdy_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_n,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_n;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle-high reset so release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/boreal_adc_frame_sched.sv
// ADS1299 RDATAC frame scheduler: DRDY edge -> 27-byte SPI capture -> raw8 commit
// -> channel 0..7 valid/ready dispatch. Define BOREAL_FRAME_STATUS_CHECK_EN to add the status-header check.
module boreal_adc_frame_sched
    import boreal_v3_pkg::*;
#(
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                ads_drdy_n,
    output logic                ads_cs_n,
    output logic                spi_start,
    input  logic                spi_done,
    input  logic [7:0]          spi_rx_byte,
    output logic [RAW_W-1:0]    raw8,
    output logic                frame_valid,
    output logic [2:0]          ch,
    output logic                ch_valid,
    input  logic                core_ready,
    output logic [15:0]         frame_cnt,
    output logic                overrun,
    input  logic                clr_overrun
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
    ,
    output logic [15:0]         hdr_err_cnt
`endif
);

    logic drdy_fall;

    boreal_drdy_sync u_drdy_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_n (ads_drdy_n),
        .fall    (drdy_fall)
    );

    sched_state_e        state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [4:0]          byte_idx_q, byte_idx_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [RAW_W-1:0]    raw8_q, raw8_d;
    logic                frame_valid_q, frame_valid_d;
    logic [2:0]          ch_q, ch_d;
    logic                ch_valid_q, ch_valid_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                overrun_q, overrun_d;
    logic                pending_q, pending_d;
    logic                discard_q, discard_d;
    logic                spi_start_q, spi_start_d;
    logic                cs_n_q, cs_n_d;
    logic                hdr_ok;
    logic                in_capture;
    logic                frame_good;

`ifdef BOREAL_FRAME_STATUS_CHECK_EN
    logic [15:0]         hdr_err_cnt_q, hdr_err_cnt_d;
    assign hdr_ok = (shadow_q[SHADOW_W-1 -: 4] == ADS_STATUS_HDR);
`else
    assign hdr_ok = 1'b1;
`endif

    assign in_capture = (state_q == CS_SETUP) || (state_q == XFER) || (state_q == CS_HOLD);
    // An edge or enable drop in the final CS_HOLD cycle must still spoil the frame.
    assign frame_good = !discard_q && !drdy_fall && enable;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        byte_idx_d    = byte_idx_q;
        shadow_d      = shadow_q;
        raw8_d        = raw8_q;
        frame_valid_d = 1'b0;
        ch_d          = ch_q;
        ch_valid_d    = ch_valid_q;
        frame_cnt_d   = frame_cnt_q;
        overrun_d     = overrun_q & ~clr_overrun;
        pending_d     = pending_q;
        discard_d     = discard_q;
        spi_start_d   = 1'b0;
        cs_n_d        = cs_n_q;
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
        hdr_err_cnt_d = hdr_err_cnt_q;
`endif

        // The SPI engine may be mid-byte, so capture always runs to the end.
        if (in_capture) begin
            if (drdy_fall) begin
                overrun_d = 1'b1;
                discard_d = 1'b1;
            end
            if (!enable) begin
                discard_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!enable) begin
                    pending_d = 1'b0;
                end else if (drdy_fall || pending_q) begin
                    state_d    = CS_SETUP;
                    cs_n_d     = 1'b0;
                    cnt_d      = '0;
                    byte_idx_d = '0;
                    pending_d  = 1'b0;
                    discard_d  = 1'b0;
                end
            end
            CS_SETUP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(CS_SETUP_CYC - 1)) begin
                    state_d     = XFER;
                    spi_start_d = 1'b1;
                end
            end
            XFER: begin
                if (spi_done) begin
                    shadow_d   = {shadow_q[SHADOW_W-9:0], spi_rx_byte};
                    byte_idx_d = byte_idx_q + 5'd1;
                    if (byte_idx_q == 5'(FRAME_BYTES - 1)) begin
                        state_d = CS_HOLD;
                        cnt_d   = '0;
                    end else begin
                        spi_start_d = 1'b1;
                    end
                end
            end
            CS_HOLD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(CS_HOLD_CYC - 1)) begin
                    cs_n_d = 1'b1;
                    if (frame_good && hdr_ok) begin
                        raw8_d        = reorder_channels(shadow_q);
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                        ch_d          = '0;
                        ch_valid_d    = 1'b1;
                        state_d       = DISPATCH;
                    end else begin
                        state_d = IDLE;
                    end
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
                    if (frame_good && !hdr_ok && (hdr_err_cnt_q != 16'hFFFF)) begin
                        hdr_err_cnt_d = hdr_err_cnt_q + 16'd1;
                    end
`endif
                end
            end
            DISPATCH: begin
                if (drdy_fall) begin
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (!enable) begin
                    ch_valid_d = 1'b0;
                    ch_d       = '0;
                    state_d    = IDLE;
                end else if (ch_valid_q && core_ready) begin
                    if (ch_q == 3'(N_CH - 1)) begin
                        ch_valid_d = 1'b0;
                        ch_d       = '0;
                        state_d    = IDLE;
                    end else begin
                        ch_d = ch_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            byte_idx_q    <= '0;
            shadow_q      <= '0;
            raw8_q        <= '0;
            frame_valid_q <= 1'b0;
            ch_q          <= '0;
            ch_valid_q    <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
            pending_q     <= 1'b0;
            discard_q     <= 1'b0;
            spi_start_q   <= 1'b0;
            cs_n_q        <= 1'b1;
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
            hdr_err_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            byte_idx_q    <= byte_idx_d;
            shadow_q      <= shadow_d;
            raw8_q        <= raw8_d;
            frame_valid_q <= frame_valid_d;
            ch_q          <= ch_d;
            ch_valid_q    <= ch_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_q     <= overrun_d;
            pending_q     <= pending_d;
            discard_q     <= discard_d;
            spi_start_q   <= spi_start_d;
            cs_n_q        <= cs_n_d;
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
            hdr_err_cnt_q <= hdr_err_cnt_d;
`endif
        end
    end

    assign ads_cs_n    = cs_n_q;
    assign spi_start   = spi_start_q;
    assign raw8        = raw8_q;
    assign frame_valid = frame_valid_q;
    assign ch          = ch_q;
    assign ch_valid    = ch_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
    assign hdr_err_cnt = hdr_err_cnt_q;
`endif

endmodule

// File: tb/tb_boreal_adc_frame_sched.sv
// Scoreboard bench for boreal_adc_frame_sched: an SPI byte model feeds frames,
// expected frames and channel offers are queued at stimulus time and popped on output.
module tb_boreal_adc_frame_sched;

    localparam int CS_SETUP_CYC = 4;
    localparam int CS_HOLD_CYC  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         ads_drdy_n;
    logic         ads_cs_n;
    logic         spi_start;
    logic         spi_done;
    logic [7:0]   spi_rx_byte;
    logic [191:0] raw8;
    logic         frame_valid;
    logic [2:0]   ch;
    logic         ch_valid;
    logic         core_ready;
    logic [15:0]  frame_cnt;
    logic         overrun;
    logic         clr_overrun;
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
    logic [15:0]  hdr_err_cnt;
`endif

    always #5 clk = ~clk;

    boreal_adc_frame_sched #(
        .CS_SETUP_CYC (CS_SETUP_CYC),
        .CS_HOLD_CYC  (CS_HOLD_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ads_drdy_n  (ads_drdy_n),
        .ads_cs_n    (ads_cs_n),
        .spi_start   (spi_start),
        .spi_done    (spi_done),
        .spi_rx_byte (spi_rx_byte),
        .raw8        (raw8),
        .frame_valid (frame_valid),
        .ch          (ch),
        .ch_valid    (ch_valid),
        .core_ready  (core_ready),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef BOREAL_FRAME_STATUS_CHECK_EN
        ,
        .hdr_err_cnt (hdr_err_cnt)
`endif
    );

    typedef struct packed {
        logic [191:0] raw;
        logic [15:0]  cnt;
    } frm_t;

    frm_t         exp_frm[$];
    int           exp_ch[$];
    logic [7:0]   frame_bytes [27];
    int           n_checks = 0;
    int           n_errs   = 0;
    int           byte_ptr = 0;
    int           spi_starts_total = 0;
    int           fv_count = 0;
    int           hs_count = 0;
    int           cv_cycles = 0;
    int           exp_cnt = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drdy_pulse();
        ads_drdy_n = 1'b0;
        tick(4);
        ads_drdy_n = 1'b1;
        tick(4);
    endtask

    task automatic load_frame(input logic [7:0] status0, input logic [7:0] base);
        frame_bytes[0] = status0;
        frame_bytes[1] = 8'h00;
        frame_bytes[2] = 8'h00;
        for (int i = 0; i < 24; i++) frame_bytes[3+i] = base + 8'(i);
    endtask

    // Channel k is the k-th 3-byte group after the status, MSB byte first.
    function automatic logic [191:0] exp_raw();
        logic [191:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[24*k +: 24] = {frame_bytes[3+3*k], frame_bytes[4+3*k], frame_bytes[5+3*k]};
        return r;
    endfunction

    task automatic push_frame(input int n_ch);
        frm_t f;
        exp_cnt++;
        f.raw = exp_raw();
        f.cnt = 16'(exp_cnt);
        exp_frm.push_back(f);
        for (int k = 0; k < n_ch; k++) exp_ch.push_back(k);
    endtask

    task automatic wait_fv(input int target);
        int n = 0;
        while (fv_count < target && n < 400) begin
            tick(1);
            n++;
        end
        check("frame_valid_wait", 192'(fv_count >= target), 192'(1));
    endtask

    task automatic wait_ch(input logic [2:0] k);
        int n = 0;
        while (!(ch_valid && ch == k) && n < 400) begin
            tick(1);
            n++;
        end
        check("ch_offer_wait", 192'(ch_valid && ch == k), 192'(1));
    endtask

    // SPI byte engine: answers each spi_start with spi_done three cycles later.
    initial begin : spi_model
        int  dly;
        bit  busy;
        dly = 0;
        busy = 1'b0;
        spi_done = 1'b0;
        spi_rx_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (ads_cs_n && !busy) byte_ptr = 0;
            if (spi_start) begin
                spi_starts_total++;
                check("cs_low_at_start", 192'(ads_cs_n), 192'(0));
                busy = 1'b1;
                dly = 2;
            end else if (busy) begin
                if (dly == 0) begin
                    spi_rx_byte = frame_bytes[byte_ptr % 27];
                    byte_ptr++;
                    spi_done = 1'b1;
                    busy = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin : monitor
        frm_t f;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ch_valid) cv_cycles++;
                if (frame_valid) begin
                    fv_count++;
                    check("frame_expected", 192'(exp_frm.size() != 0), 192'(1));
                    if (exp_frm.size() != 0) begin
                        f = exp_frm.pop_front();
                        check("raw8", raw8, f.raw);
                        check("frame_cnt", 192'(frame_cnt), 192'(f.cnt));
                    end
                end
                if (ch_valid && core_ready) begin
                    hs_count++;
                    check("handshake_expected", 192'(exp_ch.size() != 0), 192'(1));
                    if (exp_ch.size() != 0) check("ch", 192'(ch), 192'(exp_ch.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0, c0, h0, f0;
        logic [191:0] raw_bp;

        rst_n = 1'b1;
        enable = 1'b0;
        ads_drdy_n = 1'b1;
        core_ready = 1'b0;
        clr_overrun = 1'b0;
        #3;
        rst_n = 1'b0;
        tick(3);
        check("rst_cs_n", 192'(ads_cs_n), 192'(1));
        check("rst_spi_start", 192'(spi_start), 192'(0));
        check("rst_raw8", raw8, 192'(0));
        check("rst_frame_valid", 192'(frame_valid), 192'(0));
        check("rst_ch", 192'(ch), 192'(0));
        check("rst_ch_valid", 192'(ch_valid), 192'(0));
        check("rst_frame_cnt", 192'(frame_cnt), 192'(0));
        check("rst_overrun", 192'(overrun), 192'(0));
        rst_n = 1'b1;
        tick(2);
        enable = 1'b1;
        core_ready = 1'b1;

        // Single frame, core always ready.
        load_frame(8'hC0, 8'h01);
        s0 = spi_starts_total; c0 = cv_cycles; h0 = hs_count;
        push_frame(8);
        drdy_pulse();
        wait_fv(1);
        tick(30);
        check("single_spi_starts", 192'(spi_starts_total - s0), 192'(27));
        check("single_raw_ch0", 192'(raw8[23:0]), 192'(24'h010203));
        check("single_raw_ch7", 192'(raw8[191:168]), 192'(24'h161718));
        check("single_frame_cnt", 192'(frame_cnt), 192'(1));
        check("single_valid_cycles", 192'(cv_cycles - c0), 192'(8));
        check("single_handshakes", 192'(hs_count - h0), 192'(8));
        check("single_ch_drained", 192'(exp_ch.size()), 192'(0));
        check("single_cs_idle", 192'(ads_cs_n), 192'(1));
        check("single_ch_valid_low", 192'(ch_valid), 192'(0));

        // Backpressure on ch=3 for five cycles.
        load_frame(8'hC0, 8'h40);
        push_frame(8);
        raw_bp = exp_raw();
        drdy_pulse();
        wait_ch(3);
        core_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_ch_held", 192'(ch), 192'(3));
            check("bp_valid_held", 192'(ch_valid), 192'(1));
            check("bp_raw_stable", raw8, raw_bp);
        end
        core_ready = 1'b1;
        tick(1);
        check("bp_ch_next", 192'(ch), 192'(4));
        tick(20);
        check("bp_ch_drained", 192'(exp_ch.size()), 192'(0));

        // Second DRDY edge during XFER: frame discarded, overrun set.
        load_frame(8'hC0, 8'h80);
        f0 = fv_count;
        drdy_pulse();
        tick(25);
        drdy_pulse();
        tick(200);
        check("ovr_flag", 192'(overrun), 192'(1));
        check("ovr_no_frame", 192'(fv_count), 192'(f0));
        check("ovr_frame_cnt", 192'(frame_cnt), 192'(2));
        check("ovr_raw_kept", raw8, raw_bp);
        check("ovr_cs_idle", 192'(ads_cs_n), 192'(1));
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("ovr_cleared", 192'(overrun), 192'(0));

        // One edge during DISPATCH queues the next frame.
        load_frame(8'hC0, 8'h20);
        push_frame(8);
        core_ready = 1'b0;
        f0 = fv_count;
        drdy_pulse();
        wait_fv(f0 + 1);
        load_frame(8'hC0, 8'h30);
        push_frame(8);
        drdy_pulse();
        tick(2);
        core_ready = 1'b1;
        wait_ch(7);
        tick(1);
        check("pend_after_hs_valid", 192'(ch_valid), 192'(0));
        check("pend_after_hs_cs", 192'(ads_cs_n), 192'(1));
        tick(1);
        check("pend_restart_cs", 192'(ads_cs_n), 192'(0));
        check("pend_no_overrun", 192'(overrun), 192'(0));
        wait_fv(f0 + 2);
        tick(30);
        check("pend_ch_drained", 192'(exp_ch.size()), 192'(0));

        // Two edges during DISPATCH: overrun, one frame still pending.
        load_frame(8'hC0, 8'h50);
        push_frame(8);
        core_ready = 1'b0;
        f0 = fv_count;
        drdy_pulse();
        wait_fv(f0 + 1);
        load_frame(8'hC0, 8'h60);
        push_frame(8);
        drdy_pulse();
        drdy_pulse();
        check("pend2_overrun", 192'(overrun), 192'(1));
        core_ready = 1'b1;
        wait_fv(f0 + 2);
        tick(30);
        check("pend2_ch_drained", 192'(exp_ch.size()), 192'(0));
        check("pend2_frame_cnt", 192'(frame_cnt), 192'(exp_cnt));
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;

        // enable drop at ch=2, then edges ignored while disabled.
        load_frame(8'hC0, 8'h70);
        push_frame(2);
        drdy_pulse();
        wait_ch(2);
        enable = 1'b0;
        core_ready = 1'b0;
        tick(1);
        check("en_ch_valid_drop", 192'(ch_valid), 192'(0));
        check("en_ch_zero", 192'(ch), 192'(0));
        s0 = spi_starts_total;
        drdy_pulse();
        tick(20);
        check("en_off_no_start", 192'(spi_starts_total - s0), 192'(0));
        check("en_off_cs_idle", 192'(ads_cs_n), 192'(1));
        enable = 1'b1;
        tick(20);
        check("en_on_not_queued", 192'(spi_starts_total - s0), 192'(0));
        check("en_ch_drained", 192'(exp_ch.size()), 192'(0));
        load_frame(8'hC0, 8'h90);
        push_frame(8);
        core_ready = 1'b1;
        f0 = fv_count;
        drdy_pulse();
        wait_fv(f0 + 1);
        tick(30);
        check("en_resume_cnt", 192'(frame_cnt), 192'(exp_cnt));

        // Reset in the middle of a transfer.
        load_frame(8'hC0, 8'hA0);
        drdy_pulse();
        tick(30);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_async", 192'(ads_cs_n), 192'(1));
        check("mid_rst_frame_cnt", 192'(frame_cnt), 192'(0));
        check("mid_rst_raw8", raw8, 192'(0));
        check("mid_rst_spi_start", 192'(spi_start), 192'(0));
        tick(2);
        rst_n = 1'b1;
        exp_cnt = 0;
        tick(5);
        load_frame(8'hC0, 8'hB0);
        push_frame(8);
        f0 = fv_count;
        drdy_pulse();
        wait_fv(f0 + 1);
        tick(30);
        check("post_rst_cnt", 192'(frame_cnt), 192'(1));

`ifdef BOREAL_FRAME_STATUS_CHECK_EN
        // Bad status header: frame dropped and counted.
        load_frame(8'h80, 8'hC0);
        f0 = fv_count;
        drdy_pulse();
        tick(200);
        check("hdr_err_cnt", 192'(hdr_err_cnt), 192'(1));
        check("hdr_no_frame", 192'(fv_count), 192'(f0));
        check("hdr_cs_idle", 192'(ads_cs_n), 192'(1));
        check("hdr_frame_cnt", 192'(frame_cnt), 192'(exp_cnt));
`endif

        check("frames_drained", 192'(exp_frm.size()), 192'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
